// File: rtl/bcd_disp_pkg.sv
// Shared segment encodings for the BCD display path (active-high, seg[0]=a .. seg[6]=g).
// Used by bcd_to_seg7 and bcd_7seg_scanner.
package bcd_disp_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_0     = 7'h3F;
    localparam seg7_t SEG_1     = 7'h06;
    localparam seg7_t SEG_2     = 7'h5B;
    localparam seg7_t SEG_3     = 7'h4F;
    localparam seg7_t SEG_4     = 7'h66;
    localparam seg7_t SEG_5     = 7'h6D;
    localparam seg7_t SEG_6     = 7'h7D;
    localparam seg7_t SEG_7     = 7'h07;
    localparam seg7_t SEG_8     = 7'h7F;
    localparam seg7_t SEG_9     = 7'h6F;
    localparam seg7_t SEG_DASH  = 7'h40;
    localparam seg7_t SEG_BLANK = 7'h00;

    // Apply output polarity to an active-high segment pattern.
    function automatic seg7_t seg_polarity(input seg7_t seg_hi, input bit active_low);
        return active_low ? ~seg_hi : seg_hi;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to 7-segment decoder, active-high output.
// Non-decimal codes 10..15 render as a dash (segment g only).
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // NOTE: every path assigns seg (the default arm covers 10..15), so no latch is inferred.
    always_comb begin
        unique case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_7seg_scanner.sv
// Multiplexed 7-segment scanner: prescaled digit slots, per-slot blanking, once-per-frame snapshot.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits above the most significant nonzero digit.
module bcd_7seg_scanner
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYCLES   = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF    = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = AN_ACTIVE_LOW ? '1 : '0;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_tick_q, frame_tick_d;

    logic [3:0]              sel_digit;
    logic                    sel_dp;
    logic                    sel_lz;
    logic [NUM_DIGITS-1:0]   sel_onehot;
    logic [NUM_DIGITS-1:0]   lz_mask;
    seg7_t                   dec_seg;
    seg7_t                   seg_hi;

    // Prescaler, scan index and the frame-start snapshot.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        frame_tick_d = 1'b0;
        if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_q == '0 && idx_q == '0) begin
                shadow_bcd_d = bcd_in;
                shadow_dp_d  = dp_in;
                frame_tick_d = 1'b1;
            end
        end
    end

    // Leading-zero mask derives from the shadow only, so it never tears mid-frame.
    always_comb begin
        lz_mask = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic above_zero;
            above_zero = 1'b1;
            for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
                lz_mask[k] = above_zero && (shadow_bcd_q[4*k +: 4] == 4'd0);
                above_zero = lz_mask[k];
            end
        end
`endif
    end

    always_comb begin
        sel_digit  = 4'd0;
        sel_dp     = 1'b0;
        sel_lz     = 1'b0;
        sel_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_digit     = shadow_bcd_q[4*k +: 4];
                sel_dp        = shadow_dp_q[k];
                sel_lz        = lz_mask[k];
                sel_onehot[k] = 1'b1;
            end
        end
    end

    bcd_to_seg7 u_dec (
        .bcd (sel_digit),
        .seg (dec_seg)
    );

    always_comb begin
        seg_hi = sel_lz ? SEG_BLANK : dec_seg;
        if (!en || cnt_q < BLANK_END) begin
            seg_d = SEG_OFF;
            dp_d  = DP_OFF;
            an_d  = AN_OFF;
        end else begin
            seg_d = seg_polarity(seg_hi, SEG_ACTIVE_LOW);
            dp_d  = SEG_ACTIVE_LOW ? ~sel_dp : sel_dp;
            an_d  = AN_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
        end
    end

    // NOTE: non-blocking assignments here so every flop samples the pre-edge values of the others.
    // NOTE: the shadow registers are reset too, so the first frame after reset never shows X digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
// Directed self-checking bench for bcd_7seg_scanner (4 digits, 10-cycle slots, 2 blank cycles, active-low).
// Expects LEADING_ZERO_BLANK_EN to be defined or not consistently for bench and RTL.
module tb_bcd_7seg_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] bcd_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int checks = 0;
    int failures = 0;

    bcd_7seg_scanner #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (10),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT just out of reset with cnt=0, idx=0 and en still low.
    task automatic do_reset();
        en  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bcd_in = 16'h1234;
        dp_in  = 4'b0000;
        do_reset();
        en = 1'b1;
        repeat (15) step();
        checks++;
        if (an !== 4'b1101) begin
            failures++;
            $display("FAIL reset_pre an=%b expected=%b", an, 4'b1101);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_async an=%b seg=%h dp=%b ft=%b expected an=1111 seg=7f dp=1 ft=0",
                     an, seg, dp, frame_tick);
        end
        step();
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (frame_tick !== 1'b1 || an !== 4'b1111) begin
            failures++;
            $display("FAIL reset_first_tick ft=%b an=%b expected ft=1 an=1111", frame_tick, an);
        end
        step();
        checks++;
        if (frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_tick_pulse ft=%b expected=0", frame_tick);
        end
    endtask

    task automatic test_scan();
        logic [6:0] e [4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        e[0] = 7'h19; e[1] = 7'h30; e[2] = 7'h24; e[3] = 7'h79;
        bcd_in = 16'h1234;
        dp_in  = 4'b0000;
        do_reset();
        en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 10; c++) begin
                    step();
                    exp_an  = (c < 2) ? 4'b1111 : ~(4'b0001 << s);
                    exp_seg = (c < 2) ? 7'h7F : e[s];
                    checks++;
                    if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
                        failures++;
                        $display("FAIL scan f%0d s%0d c%0d an=%b seg=%h dp=%b expected an=%b seg=%h dp=1",
                                 f, s, c, an, seg, dp, exp_an, exp_seg);
                    end
                    checks++;
                    if (frame_tick !== (s == 0 && c == 0)) begin
                        failures++;
                        $display("FAIL scan_tick f%0d s%0d c%0d ft=%b expected=%b",
                                 f, s, c, frame_tick, (s == 0 && c == 0));
                    end
                end
            end
        end
    endtask

    task automatic test_coherency();
        logic [6:0] e [2][4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        e[0][0] = 7'h19; e[0][1] = 7'h30; e[0][2] = 7'h24; e[0][3] = 7'h79;
        e[1][0] = 7'h00; e[1][1] = 7'h78; e[1][2] = 7'h02; e[1][3] = 7'h12;
        bcd_in = 16'h1234;
        dp_in  = 4'b0000;
        do_reset();
        en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 10; c++) begin
                    step();
                    if (f == 0 && s == 1 && c == 4)
                        bcd_in = 16'h5678;
                    exp_an  = (c < 2) ? 4'b1111 : ~(4'b0001 << s);
                    exp_seg = (c < 2) ? 7'h7F : e[f][s];
                    checks++;
                    if (an !== exp_an || seg !== exp_seg) begin
                        failures++;
                        $display("FAIL coherency f%0d s%0d c%0d an=%b seg=%h expected an=%b seg=%h",
                                 f, s, c, an, seg, exp_an, exp_seg);
                    end
                end
            end
        end
    endtask

    task automatic test_invalid_dp();
        logic [6:0] e [4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        e[0] = 7'h3F; e[1] = 7'h3F; e[2] = 7'h40; e[3] = 7'h40;
`ifdef LEADING_ZERO_BLANK_EN
        e[2] = 7'h7F; e[3] = 7'h7F;
`endif
        bcd_in = 16'h00AF;
        dp_in  = 4'b0010;
        do_reset();
        en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 10; c++) begin
                step();
                exp_an  = (c < 2) ? 4'b1111 : ~(4'b0001 << s);
                exp_seg = (c < 2) ? 7'h7F : e[s];
                exp_dp  = !(c >= 2 && s == 1);
                checks++;
                if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
                    failures++;
                    $display("FAIL invalid_dp s%0d c%0d an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
                             s, c, an, seg, dp, exp_an, exp_seg, exp_dp);
                end
            end
        end
    endtask

    task automatic test_enable_gating();
        int steps;
        bcd_in = 16'h1234;
        dp_in  = 4'b0000;
        do_reset();
        en = 1'b1;
        step();
        checks++;
        if (frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL gate_first_tick ft=%b expected=1", frame_tick);
        end
        repeat (25) step();
        checks++;
        if (an !== 4'b1011 || seg !== 7'h24) begin
            failures++;
            $display("FAIL gate_pre an=%b seg=%h expected an=1011 seg=24", an, seg);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
                failures++;
                $display("FAIL gate_off i%0d an=%b seg=%h dp=%b ft=%b expected an=1111 seg=7f dp=1 ft=0",
                         i, an, seg, dp, frame_tick);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (an !== 4'b1011 || seg !== 7'h24) begin
                failures++;
                $display("FAIL gate_resume i%0d an=%b seg=%h expected an=1011 seg=24", i, an, seg);
            end
        end
        steps = 0;
        do begin
            step();
            steps++;
        end while (frame_tick !== 1'b1 && steps < 60);
        checks++;
        if (frame_tick !== 1'b1 || steps != 11) begin
            failures++;
            $display("FAIL gate_period period=%0d ft=%b expected period=45 ft=1",
                     1 + 25 + 5 + 4 + steps - 1, frame_tick);
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] e [2][4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
`ifdef LEADING_ZERO_BLANK_EN
        e[0][0] = 7'h40; e[0][1] = 7'h78; e[0][2] = 7'h7F; e[0][3] = 7'h7F;
        e[1][0] = 7'h40; e[1][1] = 7'h7F; e[1][2] = 7'h7F; e[1][3] = 7'h7F;
`else
        e[0][0] = 7'h40; e[0][1] = 7'h78; e[0][2] = 7'h40; e[0][3] = 7'h40;
        e[1][0] = 7'h40; e[1][1] = 7'h40; e[1][2] = 7'h40; e[1][3] = 7'h40;
`endif
        bcd_in = 16'h0070;
        dp_in  = 4'b0000;
        do_reset();
        en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 10; c++) begin
                    step();
                    exp_an  = (c < 2) ? 4'b1111 : ~(4'b0001 << s);
                    exp_seg = (c < 2) ? 7'h7F : e[f][s];
                    checks++;
                    if (an !== exp_an || seg !== exp_seg) begin
                        failures++;
                        $display("FAIL leading_zero f%0d s%0d c%0d an=%b seg=%h expected an=%b seg=%h",
                                 f, s, c, an, seg, exp_an, exp_seg);
                    end
                end
            end
            bcd_in = 16'h0000;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_coherency();
        test_invalid_dp();
        test_enable_gating();
        test_leading_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
